multi_clock_catcher: RTL and testbench

Multi-channel, parametrised catcher that makes short events from the fast `clk` domain visible to logic clocked by a slower clock, `slowClk`. `slowClk` is sampled in the `clk` domain. Each channel drives `out` high and holds it until a full slow-clock low→high transition has been observed, which guarantees the slow domain samples it at least once. Edge mode adds per-channel event counting, so back-to-back fast pulses become separate slow-domain pulses rather than being merged. The block sits between fast peripheral/strobe logic and the slow core clock domain.

---
 rtl/clock_catcher_pkg.sv | 24 ++
 rtl/multi_clock_catcher_if.sv | 31 +++
 rtl/clock_catcher_channel.sv | 101 ++++++++++
 rtl/multi_clock_catcher.sv | 54 +++++
 tb/tb_multi_clock_catcher.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_catcher_pkg.sv
// Shared types and constants for the multi-channel slow-clock event catcher.
//   state_e     : per-channel FSM states
//   MODE_LEVEL  : channel follows the level of its input
//   MODE_EDGE   : channel turns every input rising edge into one slow-visible pulse
//   drives_out(): states in which the channel output is asserted
package clock_catcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        HOLD,
        GAP_LOW,
        GAP_HIGH
    } state_e;

    localparam int unsigned MODE_LEVEL = 0;
    localparam int unsigned MODE_EDGE  = 1;

    function automatic logic drives_out(input state_e s);
        return (s == WAIT_LOW) || (s == WAIT_HIGH) || (s == HOLD);
    endfunction

endpackage

// File: rtl/multi_clock_catcher_if.sv
// Fast-domain signal bundle of the catcher.
//   in       : per-channel event/level inputs (driven by master)
//   ovf_clr  : one-cycle pulse clearing all overflow flags (driven by master)
//   out      : per-channel stretched outputs (driven by slave)
//   overflow : per-channel sticky lost-event flags (driven by slave)
//   busy     : any channel active or holding pending events (driven by slave)
interface multi_clock_catcher_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic                ovf_clr;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] overflow;
    logic                busy;

    modport master (
        output in,
        output ovf_clr,
        input  out,
        input  overflow,
        input  busy
    );

    modport slave (
        input  in,
        input  ovf_clr,
        output out,
        output overflow,
        output busy
    );
endinterface

// File: rtl/clock_catcher_channel.sv
// One catcher channel: FSM, pending-event counter, input edge register and overflow flag.
//   clk, rst_n : fast clock, asynchronous active-low reset
//   in         : event/level input
//   sc         : synchronised slow clock
//   ovf_clr    : clears the overflow flag (a same-cycle overflow wins)
//   out        : registered stretched output
//   overflow   : sticky flag, an edge was dropped with the counter saturated
//   busy       : FSM not idle or events still pending
module clock_catcher_channel
    import clock_catcher_pkg::*;
#(
    parameter int unsigned MODE  = MODE_EDGE,
    parameter int unsigned CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    input  logic sc,
    input  logic ovf_clr,
    output logic out,
    output logic overflow,
    output logic busy
);
    localparam bit               IsEdge = (MODE == MODE_EDGE);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q;
    logic [CNT_W-1:0] pending_q;
    logic             in_d_q;

    logic has_pend;
    logic rise;
    logic take;
    logic inc;
    logic lost;

    assign has_pend = (pending_q != '0);
    assign rise     = IsEdge && in && !in_d_q;
    // A pending event is consumed when IDLE or GAP_HIGH launches the next pulse.
    assign take     = IsEdge && has_pend &&
                      ((state_q == IDLE) || ((state_q == GAP_HIGH) && sc));
    // A rise in IDLE with nothing queued starts a pulse directly instead of counting.
    assign inc      = rise && !((state_q == IDLE) && !has_pend);
    assign lost     = inc && !take && (pending_q == CntMax);
    assign busy     = (state_q != IDLE) || has_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            in_d_q    <= 1'b0;
            out       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            in_d_q <= in;
            out    <= drives_out(state_q);

            if (lost) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (inc && !take) begin
                if (pending_q != CntMax) begin
                    pending_q <= pending_q + CNT_W'(1);
                end
            end else if (take && !inc) begin
                pending_q <= pending_q - CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (IsEdge ? (rise || has_pend) : in) begin
                        state_q <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!sc) state_q <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (sc) begin
                        if (IsEdge)  state_q <= GAP_LOW;
                        else if (in) state_q <= HOLD;
                        else         state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (!in) state_q <= IDLE;
                end
                GAP_LOW: begin
                    if (!sc) state_q <= GAP_HIGH;
                end
                GAP_HIGH: begin
                    if (sc) state_q <= has_pend ? WAIT_LOW : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/multi_clock_catcher.sv
// Multi-channel catcher making fast-domain events visible to a slower clock domain.
//   clk, rst_n : fast clock, asynchronous active-low reset
//   slowClk    : slow clock, sampled as data through a SYNC_STAGES-deep synchroniser
//   bus        : in/ovf_clr inputs and out/overflow/busy outputs (slave modport)
module multi_clock_catcher
    import clock_catcher_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned MODE        = MODE_EDGE,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  slowClk,
    multi_clock_catcher_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sc;
    logic [CHANNELS-1:0]    ch_out;
    logic [CHANNELS-1:0]    ch_ovf;
    logic [CHANNELS-1:0]    ch_busy;

    // Shift towards the MSB; the MSB is the synchronised slow clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(slowClk);
        end
    end

    assign sc = sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        clock_catcher_channel #(
            .MODE  (MODE),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .in       (bus.in[g]),
            .sc       (sc),
            .ovf_clr  (bus.ovf_clr),
            .out      (ch_out[g]),
            .overflow (ch_ovf[g]),
            .busy     (ch_busy[g])
        );
    end

    assign bus.out      = ch_out;
    assign bus.overflow = ch_ovf;
    assign bus.busy     = |ch_busy;
endmodule

// File: tb/tb_multi_clock_catcher.sv
// Directed bench: one level-mode and one edge-mode catcher share clocks and reset.
// Expected pulses are queued as stimulus is applied and retired by a pulse monitor.
module tb_multi_clock_catcher;
    import clock_catcher_pkg::*;

    logic clk;
    logic rst_n;
    logic slow_clk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int sb_q[$];

    multi_clock_catcher_if #(.CHANNELS(4)) bus_l ();
    multi_clock_catcher_if #(.CHANNELS(4)) bus_e ();

    multi_clock_catcher #(
        .CHANNELS    (4),
        .MODE        (MODE_LEVEL),
        .CNT_W       (3),
        .SYNC_STAGES (2)
    ) u_lvl (
        .clk     (clk),
        .rst_n   (rst_n),
        .slowClk (slow_clk),
        .bus     (bus_l)
    );

    multi_clock_catcher #(
        .CHANNELS    (4),
        .MODE        (MODE_EDGE),
        .CNT_W       (3),
        .SYNC_STAGES (2)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .slowClk (slow_clk),
        .bus     (bus_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slow clock: 16 fast cycles per period, edges kept away from clk edges.
    initial begin
        slow_clk = 1'b0;
        #2;
        forever #80 slow_clk = ~slow_clk;
    end

    // Reference two-stage synchroniser plus one extra delay stage for the pulse monitor.
    logic [1:0] sync_tb;
    logic       sc_ref;
    logic       sc_d1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_tb <= 2'b00;
            sc_d1   <= 1'b0;
        end else begin
            sync_tb <= {sync_tb[0], slow_clk};
            sc_d1   <= sync_tb[1];
        end
    end
    assign sc_ref = sync_tb[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: every out pulse must span an sc low->high, edge-mode gaps likewise,
    // and each completed pulse retires the oldest expected entry (code = dut*4 + ch).
    bit prev_o [2][4];
    bit seen0  [2][4];
    bit seen01 [2][4];
    bit g0     [2][4];
    bit g01    [2][4];
    bit have_p [2][4];
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    logic o;
                    int   got;
                    o = (d == 1) ? bus_e.out[c] : bus_l.out[c];
                    if (!rst_n) begin
                        prev_o[d][c] = 1'b0;
                        seen0[d][c]  = 1'b0;
                        seen01[d][c] = 1'b0;
                        g0[d][c]     = 1'b0;
                        g01[d][c]    = 1'b0;
                        have_p[d][c] = 1'b0;
                    end else begin
                        if (o && !prev_o[d][c]) begin
                            if (d == 1 && have_p[d][c]) check("gap_span", g01[d][c], 1);
                            seen0[d][c]  = 1'b0;
                            seen01[d][c] = 1'b0;
                        end
                        if (!o && prev_o[d][c]) begin
                            check("pulse_span", seen01[d][c], 1);
                            check("sb_nonempty", sb_q.size() != 0, 1);
                            if (sb_q.size() != 0) begin
                                got = sb_q.pop_front();
                                check("sb_order", got, d * 4 + c);
                            end
                            have_p[d][c] = 1'b1;
                            g0[d][c]     = 1'b0;
                            g01[d][c]    = 1'b0;
                        end
                        if (o) begin
                            if (!sc_d1)           seen0[d][c]  = 1'b1;
                            else if (seen0[d][c]) seen01[d][c] = 1'b1;
                        end else begin
                            if (!sc_d1)        g0[d][c]  = 1'b1;
                            else if (g0[d][c]) g01[d][c] = 1'b1;
                        end
                        prev_o[d][c] = o;
                    end
                end
            end
        end
    end

    task automatic wait_sc(input logic val);
        bit found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sc_ref == val) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("sc_timeout", found, 1);
    endtask

    // Returns at the first negedge where sc_ref has just turned 1.
    task automatic wait_sc_rise();
        wait_sc(1'b0);
        wait_sc(1'b1);
    endtask

    task automatic wait_out(input int ch, input logic val, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus_e.out[ch] == val) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("out_timeout", found, 1);
    endtask

    task automatic wait_idle(input bit edge_dut, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!(edge_dut ? bus_e.busy : bus_l.busy)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("idle_timeout", found, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic edge_pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            bus_e.in[ch] = 1'b1;
            @(negedge clk);
            bus_e.in[ch] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n         = 1'b0;
        bus_l.in      = '0;
        bus_l.ovf_clr = 1'b0;
        bus_e.in      = '0;
        bus_e.ovf_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_lvl_out", bus_l.out, 0);
        check("rst_lvl_ovf", bus_l.overflow, 0);
        check("rst_lvl_busy", bus_l.busy, 0);
        check("rst_edge_out", bus_e.out, 0);
        check("rst_edge_ovf", bus_e.overflow, 0);
        check("rst_edge_busy", bus_e.busy, 0);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Level mode: single-cycle input pulse is stretched
        sb_q.push_back(0);
        bus_l.in[0] = 1'b1;
        @(negedge clk);
        bus_l.in[0] = 1'b0;
        check("lvl_lat_pre", bus_l.out[0], 0);
        @(negedge clk);
        check("lvl_lat_post", bus_l.out[0], 1);
        wait_idle(1'b0, 200);
        check("lvl_busy_idle", bus_l.busy, 0);
        check("lvl_ovf_zero", bus_l.overflow, 0);
        check("lvl_sb_empty", sb_q.size(), 0);

        // Level mode: long input level keeps out high, release lags input by one cycle
        sb_q.push_back(0);
        bad = 0;
        bus_l.in[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i >= 2 && bus_l.out[0] !== 1'b1) bad++;
        end
        check("hold_high", bad, 0);
        bus_l.in[0] = 1'b0;
        @(negedge clk);
        check("hold_fall_pre", bus_l.out[0], 1);
        @(negedge clk);
        check("hold_fall_post", bus_l.out[0], 0);
        wait_idle(1'b0, 100);
        check("hold_sb_empty", sb_q.size(), 0);

        // Edge mode: three pulses two cycles apart give three separate slow pulses
        repeat (3) sb_q.push_back(4 + 1);
        bus_e.in[1] = 1'b1;
        @(negedge clk);
        bus_e.in[1] = 1'b0;
        check("edge_lat_pre", bus_e.out[1], 0);
        @(negedge clk);
        check("edge_lat_post", bus_e.out[1], 1);
        edge_pulses(1, 2);
        wait_idle(1'b1, 400);
        check("edge3_busy", bus_e.busy, 0);
        check("edge3_out", bus_e.out, 0);
        check("edge3_count", sb_q.size(), 0);

        // Edge mode: ten pulses within one delivery saturate the counter
        wait_sc_rise();
        repeat (8) sb_q.push_back(4 + 2);
        edge_pulses(2, 10);
        check("ovf_set", bus_e.overflow, 4'b0100);
        wait_idle(1'b1, 600);
        check("ovf_count", sb_q.size(), 0);
        check("ovf_sticky", bus_e.overflow, 4'b0100);
        bus_e.ovf_clr = 1'b1;
        @(negedge clk);
        bus_e.ovf_clr = 1'b0;
        check("ovf_cleared", bus_e.overflow, 0);

        // Clear request coincident with a fresh overflow: the overflow wins
        wait_sc_rise();
        repeat (8) sb_q.push_back(4 + 2);
        edge_pulses(2, 9);
        bus_e.in[2]   = 1'b1;
        bus_e.ovf_clr = 1'b1;
        @(negedge clk);
        bus_e.in[2]   = 1'b0;
        bus_e.ovf_clr = 1'b0;
        check("ovf_set_wins", bus_e.overflow, 4'b0100);
        @(negedge clk);
        wait_idle(1'b1, 600);
        check("ovf2_count", sb_q.size(), 0);

        // Rise exactly at GAP_HIGH exit with two pending: four deliveries in total
        wait_sc_rise();
        repeat (3) sb_q.push_back(4 + 3);
        edge_pulses(3, 3);
        wait_out(3, 1'b1, 200);
        wait_out(3, 1'b0, 200);
        wait_sc(1'b0);
        wait_sc(1'b1);
        bus_e.in[3] = 1'b1;
        sb_q.push_back(4 + 3);
        @(negedge clk);
        bus_e.in[3] = 1'b0;
        check("coinc_pre", bus_e.out[3], 0);
        @(negedge clk);
        check("coinc_post", bus_e.out[3], 1);
        wait_idle(1'b1, 600);
        check("coinc_count", sb_q.size(), 0);

        // Asynchronous reset in WAIT_HIGH with three pending events
        wait_sc_rise();
        repeat (4) sb_q.push_back(4 + 0);
        edge_pulses(0, 4);
        wait_sc(1'b0);
        repeat (2) @(negedge clk);
        check("rst_pre_out", bus_e.out[0], 1);
        check("rst_pre_busy", bus_e.busy, 1);
        check("rst_pre_ovf", bus_e.overflow, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", bus_e.out, 0);
        check("rst_async_busy", bus_e.busy, 0);
        check("rst_async_ovf", bus_e.overflow, 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_e.busy || (bus_e.out != 0)) bad++;
        end
        check("quiet_after_rst", bad, 0);

        // Input already high at reset release counts as one edge
        @(negedge clk);
        rst_n = 1'b0;
        bus_e.in[0] = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        sb_q.push_back(4 + 0);
        repeat (4) @(negedge clk);
        check("rel_high_busy", bus_e.busy, 1);
        bus_e.in[0] = 1'b0;
        wait_idle(1'b1, 200);
        check("rel_high_count", sb_q.size(), 0);

        repeat (4) @(negedge clk);
        check("sb_final_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
